// File: rtl/ufp_traffic_gen.sv
// ufp_traffic_gen: LFSR-driven read/write traffic master for the cache UFP port.
// Optional read-data signature is built when UFP_TRAFFIC_GEN_SIG_EN is defined.
module ufp_traffic_gen #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          OFS_LSB   = 2,
    parameter int          OFS_W     = 3,
    parameter int          SET_W     = 4,
    parameter int          TAG_W     = 7,
    parameter int          CNT_W     = 20,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_1234,
    localparam int         MASK_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_txn,
    input  logic [8:0]        wr_thresh,
    input  logic [TAG_W-1:0]  tag_base,
    input  logic [TAG_W-1:0]  tag_mask,
    input  logic              idle_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ufp_addr,
    output logic [MASK_W-1:0] ufp_rmask,
    output logic [MASK_W-1:0] ufp_wmask,
    output logic [DATA_W-1:0] ufp_wdata,
    input  logic [DATA_W-1:0] ufp_rdata,
    input  logic              ufp_resp,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [DATA_W-1:0] sig
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

    state_t             state, state_nx;
    logic [31:0]        lfsr, lfsr_nx;
    logic [CNT_W-1:0]   remaining, idx, req_idx;
    logic [3:0]         gap;
    logic               out_wr;
    logic               issue, clr, fin, to_gap, resp_ok;
    logic               is_wr;
    logic [TAG_W-1:0]   tag;
    logic [ADDR_W-1:0]  req_addr;
    logic [MASK_W-1:0]  req_wmask;
    logic [DATA_W-1:0]  req_wdata;

    assign lfsr_nx = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);

    // Request fields are decoded from the lfsr value before it advances.
    assign tag      = tag_base + (TAG_W'(lfsr[15:8]) & tag_mask);
    assign req_addr = (ADDR_W'(lfsr[OFS_W-1:0]) << OFS_LSB)
                    | (ADDR_W'(lfsr[OFS_W+SET_W-1:OFS_W]) << (OFS_LSB + OFS_W))
                    | (ADDR_W'(tag) << (OFS_LSB + OFS_W + SET_W));
    assign is_wr     = {1'b0, lfsr[23:16]} < wr_thresh;
    assign req_wmask = (lfsr[24 +: MASK_W] == '0) ? '1 : lfsr[24 +: MASK_W];
    assign req_idx   = clr ? '0 : idx;
    assign req_wdata = lfsr[DATA_W-1:0] ^ DATA_W'(req_idx);
    assign resp_ok   = (state == ISSUE) && ufp_resp;

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        clr      = 1'b0;
        fin      = 1'b0;
        to_gap   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start && num_txn != '0) begin
                    state_nx = ISSUE;
                    issue    = 1'b1;
                    clr      = 1'b1;
                end else if (start) begin
                    state_nx = DONE;
                    fin      = 1'b1;
                end
            end
            ISSUE: begin
                if (ufp_resp) begin
                    if (remaining == '0) begin
                        state_nx = DONE;
                        fin      = 1'b1;
                    end else if (idle_en && lfsr[31:28] != 4'd0) begin
                        state_nx = GAP;
                        to_gap   = 1'b1;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap == 4'd1) begin
                    state_nx = ISSUE;
                    issue    = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lfsr      <= LFSR_SEED;
            remaining <= '0;
            idx       <= '0;
            gap       <= '0;
            out_wr    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ufp_addr  <= '0;
            ufp_rmask <= '0;
            ufp_wmask <= '0;
            ufp_wdata <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
        end else begin
            state <= state_nx;
            if (issue) begin
                lfsr      <= lfsr_nx;
                idx       <= req_idx + 1'b1;
                remaining <= clr ? num_txn - 1'b1 : remaining - 1'b1;
                out_wr    <= is_wr;
                ufp_addr  <= req_addr;
                ufp_rmask <= is_wr ? '0 : '1;
                ufp_wmask <= is_wr ? req_wmask : '0;
                ufp_wdata <= is_wr ? req_wdata : '0;
            end else if (to_gap || fin) begin
                ufp_rmask <= '0;
                ufp_wmask <= '0;
            end
            if (to_gap) gap <= lfsr[31:28];
            else if (state == GAP) gap <= gap - 4'd1;
            if (clr) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (fin) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (ufp_resp && state != ISSUE) err <= 1'b1;
            if (clr) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else if (resp_ok && out_wr) begin
                if (wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
            end else if (resp_ok) begin
                if (rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

`ifdef UFP_TRAFFIC_GEN_SIG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sig <= '0;
        else if (clr) sig <= '0;
        else if (resp_ok && !out_wr) sig <= {sig[DATA_W-2:0], sig[DATA_W-1]} ^ ufp_rdata;
    end
`else
    assign sig = '0;
`endif

endmodule

// File: tb/tb_ufp_traffic_gen.sv
// Randomized directed bench for ufp_traffic_gen with a transaction-level model.
// Models the read-data signature when UFP_TRAFFIC_GEN_SIG_EN is defined.
module tb_ufp_traffic_gen;

    localparam logic [31:0] SEED = 32'hACE1_1234;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] num_txn;
    logic [8:0]  wr_thresh;
    logic [6:0]  tag_base;
    logic [6:0]  tag_mask;
    logic        idle_en;
    logic        busy, done, err;
    logic [31:0] ufp_addr;
    logic [3:0]  ufp_rmask, ufp_wmask;
    logic [31:0] ufp_wdata;
    logic [31:0] ufp_rdata;
    logic        ufp_resp;
    logic [19:0] rd_cnt, wr_cnt;
    logic [31:0] sig;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_lfsr;
    logic        m_err;
    int          last_rd, last_wr;

    ufp_traffic_gen dut (
        .clk(clk), .rst(rst), .start(start), .num_txn(num_txn),
        .wr_thresh(wr_thresh), .tag_base(tag_base), .tag_mask(tag_mask),
        .idle_en(idle_en), .busy(busy), .done(done), .err(err),
        .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_wmask(ufp_wmask),
        .ufp_wdata(ufp_wdata), .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .sig(sig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'hC3A5_9617;
    endfunction

    task automatic all_zero(input string tag);
        chk({tag, "_addr"}, ufp_addr, 0);
        chk({tag, "_masks"}, {ufp_rmask, ufp_wmask}, 0);
        chk({tag, "_wdata"}, ufp_wdata, 0);
        chk({tag, "_flags"}, {busy, done, err}, 0);
        chk({tag, "_cnts"}, {rd_cnt, wr_cnt}, 0);
        chk({tag, "_sig"}, sig, 0);
    endtask

    // Entered and left on a negedge.
    task automatic run(input int n, input int thr, input bit idle, input int lat,
                       input logic [6:0] tb, input logic [6:0] tm,
                       input int abort_at, input int busy_at, input bit tag_chk);
        logic [31:0] v, ea, ewd, esig;
        logic [3:0]  ewm, erm;
        logic [6:0]  etag;
        bit          wr;
        int          rds, wrs, g;
        rds = 0; wrs = 0; esig = 0;
        num_txn = 20'(n); wr_thresh = 9'(thr); idle_en = idle;
        tag_base = tb; tag_mask = tm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            v = m_lfsr;
            m_lfsr = step(v);
            etag = tb + (v[15:8] & 8'(tm));
            ea = {16'h0, etag, v[6:3], v[2:0], 2'b00};
            wr = {1'b0, v[23:16]} < thr;
            ewm = wr ? ((v[27:24] == 0) ? 4'hF : v[27:24]) : 4'h0;
            erm = wr ? 4'h0 : 4'hF;
            ewd = wr ? (v ^ 32'(k)) : 32'h0;
            if (k == 0) chk("run_start_flags", {busy, done}, 2'b10);
            if (k == 0 && tag_chk)
                chk("tag_in_range", (ufp_addr[15:9] >= 7'h12 && ufp_addr[15:9] <= 7'h15), 1);
            if (k == abort_at) begin
                rst = 1'b0;
                #1;
                all_zero("abort");
                m_lfsr = SEED;
                m_err = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            for (int c = 1; c <= lat; c++) begin
                chk("req_addr", ufp_addr, ea);
                chk("req_masks", {ufp_rmask, ufp_wmask}, {erm, ewm});
                chk("req_wdata", ufp_wdata, ewd);
                if (k == busy_at && c == 1) begin
                    start = 1'b1;
                    num_txn = 20'd5;
                end
                if (c == lat) begin
                    ufp_resp = 1'b1;
                    ufp_rdata = mem(ea);
                end
                @(negedge clk);
                start = 1'b0;
                ufp_resp = 1'b0;
                ufp_rdata = $urandom;
            end
            if (wr) wrs++;
            else begin
                rds++;
`ifdef UFP_TRAFFIC_GEN_SIG_EN
                esig = {esig[30:0], esig[31]} ^ mem(ea);
`endif
            end
            g = (k < n - 1 && idle && m_lfsr[31:28] != 0) ? int'(m_lfsr[31:28]) : 0;
            for (int j = 0; j < g; j++) begin
                chk("gap_masks", {ufp_rmask, ufp_wmask}, 0);
                @(negedge clk);
            end
        end
        chk("end_flags", {busy, done}, 2'b01);
        chk("end_masks", {ufp_rmask, ufp_wmask}, 0);
        chk("rd_cnt", rd_cnt, rds);
        chk("wr_cnt", wr_cnt, wrs);
        chk("sig", sig, esig);
        chk("err", err, m_err);
        last_rd = rds;
        last_wr = wrs;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; num_txn = '0; wr_thresh = '0;
        tag_base = '0; tag_mask = '0; idle_en = 1'b0;
        ufp_resp = 1'b0; ufp_rdata = '0;
        m_lfsr = SEED; m_err = 1'b0; last_rd = 0; last_wr = 0;
        @(negedge clk);
        all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // zero-length run: done one cycle after start, no traffic
        num_txn = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_run_flags", {busy, done}, 2'b01);
        for (int i = 0; i < 3; i++) begin
            chk("zero_run_masks", {ufp_rmask, ufp_wmask}, 0);
            @(negedge clk);
        end

        // back-to-back hits, all reads, first address from the seed
        run(256, 0, 1'b0, 1, 7'h12, 7'h03, -1, -1, 1'b1);
        // all writes, long latency, start while busy
        run(16, 256, 1'b0, 20, 7'h12, 7'h03, -1, 3, 1'b0);
        // random mix with idle gaps
        run(64, $urandom_range(0, 300), 1'b1, $urandom_range(1, 3),
            7'($urandom), 7'($urandom), -1, -1, 1'b0);

        // spurious response while done
        ufp_resp = 1'b1;
        @(negedge clk);
        ufp_resp = 1'b0;
        m_err = 1'b1;
        chk("err_set", err, 1);
        chk("err_rd_cnt", rd_cnt, last_rd);
        chk("err_wr_cnt", wr_cnt, last_wr);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);
        run(8, $urandom_range(0, 256), 1'b0, 1, 7'h12, 7'h03, -1, -1, 1'b0);

        // mid-run reset, then clean rerun from the seed
        begin
            int thr;
            thr = $urandom_range(0, 256);
            run(100, thr, 1'b0, 2, 7'h12, 7'h03, 10, -1, 1'b0);
            run(100, thr, 1'b0, 2, 7'h12, 7'h03, -1, -1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ufp_traffic_gen.md
Name: ufp_traffic_gen

Overview:
- Synthesizable, parametrised upstream-port (UFP) traffic master for the pipelined set-associative cache.
- Generates a programmable count of pseudo-random, field-constrained reads and writes using the pipelined UFP handshake. A new request is driven on the edge where the previous `ufp_resp` is sampled.
- Counts completions and folds read data into a signature. Used for on-chip and emulation cache stress, in place of bench-only stimulus.

Parameters:
- ADDR_W, 32, UFP address width.
- DATA_W, 32, UFP data width; MASK_W = DATA_W/8.
- OFS_LSB, 2, lsb of word-offset field.
- OFS_W, 3, word-offset field width.
- SET_W, 4, set-index field width (sits directly above offset).
- TAG_W, 7, tag field width (sits directly above set).
- CNT_W, 20, transaction-count and counter width.
- LFSR_SEED, 32'hACE1_1234, LFSR reset value (must be nonzero).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a run when not busy
- num_txn  in  CNT_W  transactions per run, sampled at start
- wr_thresh  in  9  write probability: write if {1'b0,lfsr[23:16]} < wr_thresh
- tag_base  in  TAG_W  tag base
- tag_mask  in  TAG_W  tag span mask
- idle_en  in  1  enable random idle gaps
- busy  out  1  run in progress
- done  out  1  run complete; held until next start
- err  out  1  sticky protocol error
- ufp_addr  out  ADDR_W  request address
- ufp_rmask  out  MASK_W  read mask
- ufp_wmask  out  MASK_W  write mask
- ufp_wdata  out  DATA_W  write data
- ufp_rdata  in  DATA_W  read data, valid with resp
- ufp_resp  in  1  response
- rd_cnt  out  CNT_W  completed reads
- wr_cnt  out  CNT_W  completed writes
- sig  out  DATA_W  read-data signature

Behaviour:
- Reset values:
  - All outputs 0, state IDLE.
  - lfsr = LFSR_SEED.
- LFSR:
  - 32-bit Galois, taps 32'h8020_0003.
  - Advances exactly once per issued request, on the issuing edge.
- Request fields from the current lfsr value:
  - addr[OFS_LSB-1:0] = 0.
  - offset = lfsr[OFS_W-1:0].
  - set = lfsr[OFS_W+SET_W-1:OFS_W].
  - tag = tag_base + (lfsr[15:8] & tag_mask), TAG_W wrap-around.
  - Bits above the tag = 0.
- Write decision:
  - Write iff {1'b0,lfsr[23:16]} < wr_thresh.
  - wr_thresh = 0 gives all reads; wr_thresh >= 256 gives all writes.
- Write request:
  - wmask = lfsr[27:24], replaced by all-ones if zero.
  - rmask = 0.
  - wdata = lfsr[DATA_W-1:0] ^ issue index (zero-extended).
- Read request: rmask all-ones, wmask 0, wdata 0.
- Request hold: fields held stable from issue until the edge where ufp_resp = 1 is sampled.
- States:
  - IDLE:
    - start=1 and num_txn != 0 -> ISSUE. Drive the first request on this edge; latch remaining = num_txn-1; busy=1; done=0; clear rd_cnt, wr_cnt and sig.
    - start=1 and num_txn = 0 -> DONE on the next edge.
  - ISSUE:
    - On resp: increment rd_cnt or wr_cnt per the outstanding type.
    - remaining = 0 -> DONE; masks driven to 0 on the same edge.
    - Else, idle_en=1 and lfsr[31:28] != 0 -> GAP. gap = lfsr[31:28]; masks 0.
    - Else, drive the next request on the same edge (zero-bubble back-to-back); remaining decrements.
  - GAP:
    - Masks 0; gap decrements each cycle.
    - gap reaches 1 -> ISSUE and drive the next request.
  - DONE:
    - busy=0, done=1.
    - start=1 behaves as in IDLE.
- Error and edge conditions:
  - start while busy is ignored.
  - ufp_resp while no request is outstanding (IDLE, GAP, DONE) sets err. err is cleared only by reset; counters are unaffected.
  - Reset mid-run aborts immediately: masks 0, counters and lfsr reinitialised.
- Throughput:
  - A cache with 1-cycle hit response sees one request per cycle when idle_en=0.
- Counters saturate at all-ones.

Optional Feature:
- Macro: UFP_TRAFFIC_GEN_SIG_EN.
- Defined: on each read response, sig <= {sig[DATA_W-2:0], sig[DATA_W-1]} ^ ufp_rdata. Write responses do not change sig.
- Undefined: sig is tied to 0 and the signature logic is not built.

Test Plan:
- Reset and seed: rst low with no traffic, then released -> all outputs 0; first run's first ufp_addr equals the value computed from 32'hACE1_1234 with tag_base=7'h12, tag_mask=7'h03, giving tag in 0x12..0x15.
- Back-to-back hits: num_txn=256, wr_thresh=0, idle_en=0, responder with resp 1 cycle after each request -> 256 consecutive cycles with rmask=4'hF; rd_cnt=256, wr_cnt=0; done 1 cycle after the last resp.
- All-writes with miss latency: wr_thresh=256, responder latency 20 cycles -> every wmask nonzero and each request held 20 cycles; wr_cnt=num_txn=16.
- Idle gaps: idle_en=1, num_txn=64 -> each gap length equals lfsr[31:28] at the preceding resp; no mask asserted during gaps.
- Edge cases: num_txn=0 -> done=1 one cycle after start with zero ufp traffic; spurious resp in DONE -> err=1 and sticky; start while busy -> ignored.
- Mid-run reset and signature: rst low at transaction 10 of 100 -> outputs 0 next edge; rerun of 100 gives the same addresses and, with UFP_TRAFFIC_GEN_SIG_EN, the same sig as a clean run against a deterministic memory.
